alu_chain: RTL
==============

ALU_CHAIN -- requirements
Module: alu_chain

Interface
REQ-001 SHALL have parameter BYTES, default 2, giving operand width in bytes (legal 1..4).
REQ-002 SHALL have parameter HALF_FROM_TOP, default 1: 1 takes H/C of ADDW from the top byte, 0 from byte 0.
REQ-003 clk  input  1  sole clock; all state on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only while idle.
REQ-006 op  input  alu_op_t  ADD, ADC, SUB, SBC, CP, AND, OR, XOR, ADDW, ADDSPE.
REQ-007 acc_in  input  8*BYTES  accumulator operand.
REQ-008 arg_in  input  8*BYTES  argument operand; ADDSPE uses only arg_in[7:0].
REQ-009 f_in  input  flags_t  incoming flags {z,n,h,c}; c is carry-in, z is preserved by ADDW.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 res  output  8*BYTES  result.
REQ-013 f_out  output  flags_t  result flags.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and RUN; IDLE->RUN on start in IDLE; RUN->IDLE after byte BYTES-1 is processed.
REQ-015 On entering RUN, acc_in, arg_in, op and f_in SHALL be latched; later input changes are ignored until done.
REQ-016 SHALL process one byte per cycle, LSB first, using a byte index counter 0..BYTES-1.
REQ-017 SHALL carry the inter-byte carry in a register between cycles.
REQ-018 Start sampled at edge k SHALL produce done=1 and final res/f_out in the cycle after edge k+BYTES; busy high during cycles k+1..k+BYTES.
REQ-019 res and f_out SHALL hold their values after done until the next start is accepted.
REQ-020 start while busy SHALL be ignored: no queueing, no error.
REQ-021 Initial carry-in: 0 for ADD/ADDW/ADDSPE, f_in.c for ADC, 1 for SUB/CP, ~f_in.c for SBC.
REQ-022 SUB/SBC/CP SHALL add the bitwise-inverted argument.
REQ-023 For subtraction ops, C and H SHALL be reported as borrow, i.e. inverted carry-out and inverted nibble carry.
REQ-024 CP SHALL compute flags as SUB but return res = latched acc_in.
REQ-025 Arithmetic flags: Z = full-width result zero; N = 1 for SUB/SBC/CP, else 0; H and C from the most significant byte.
REQ-026 AND/OR/XOR: Z per result; N=0; C=0; H=1 for AND, 0 otherwise.
REQ-027 ADDW: Z = f_in.z (preserved); N=0; H/C taken from the byte selected by HALF_FROM_TOP.
REQ-028 ADDSPE: argument = sign-extension of arg_in[7:0] to 8*BYTES; Z=0; N=0; H/C from byte 0.
REQ-029 Width rule: all carries SHALL be computed without overflow loss; res wraps modulo 2^(8*BYTES).
REQ-030 BYTES=1 SHALL give done one cycle after start, with behaviour otherwise identical.

Reset
REQ-031 rst low SHALL force FSM=IDLE, counter=0, carry=0, busy=0, done=0, res=0, f_out=0 without waiting for clk.
REQ-032 Reset during RUN SHALL abort the operation with no done pulse; operation SHALL resume from IDLE on the first edge after rst deasserts.

Structure
REQ-033 alu_op_t (extended with ADDW, ADDSPE) and flags_t SHALL live in the shared sm83 package; no local redefinition.
REQ-034 A combinational sub-module alu_byte (8-bit slice: acc, arg, carry-in -> sum, half-carry, carry-out, logic result) SHALL be instantiated once and reused each cycle.

Verification
REQ-035 BYTES=2, ADD 16'h00FF + 16'h0001, f_in=0 -> done 2 cycles after start, res=16'h0100, f_out={0,0,0,0}.
REQ-036 BYTES=2, ADDW 16'h0FFF + 16'h0001, f_in.z=1 -> res=16'h1000, f_out={1,0,1,0}.
REQ-037 BYTES=2, ADDSPE acc=16'hFFF8, arg[7:0]=8'h08 -> res=16'h0000, f_out={0,0,1,1}.
REQ-038 BYTES=1, SUB 8'h10 - 8'h20 -> res=8'hF0, f_out={0,1,0,1}; CP 8'h3C vs 8'h3C -> res=8'h3C, f_out={1,1,0,0}.
REQ-039 BYTES=2, start ADD then rst low after one RUN cycle -> busy/done/res=0 immediately; no done pulse; a fresh start afterwards completes normally.
REQ-040 start held high across a whole operation -> exactly one done per accepted start; mid-run start pulses ignored.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared SM83 ALU types.
//   alu_op_t : ALU operation select (base ops plus the 16-bit ADDW / ADDSPE forms)
//   flags_t  : flag nibble {z, n, h, c}
//   is_sub     : true for ops that add the inverted argument and report borrow
//   init_carry : carry into byte 0 for a given op and incoming carry flag
package sm83_pkg;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_ADC,
    OP_SUB,
    OP_SBC,
    OP_CP,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_ADDW,
    OP_ADDSPE
  } alu_op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  function automatic logic is_sub(input alu_op_t op);
    return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
  endfunction

  function automatic logic init_carry(input alu_op_t op, input logic c);
    case (op)
      OP_ADC:        return c;
      OP_SUB, OP_CP: return 1'b1;
      OP_SBC:        return ~c;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_byte.sv
// Combinational 8-bit ALU slice.
//   a, b  : byte operands (b already inverted / extended by the caller)
//   cin   : carry into this byte
//   op    : selects the bitwise function for lres
//   sum   : a + b + cin (low 8 bits)
//   half  : carry out of bit 3
//   cout  : carry out of bit 7
//   lres  : a AND/OR/XOR b
module alu_byte
  import sm83_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  alu_op_t    op,
  output logic [7:0] sum,
  output logic       half,
  output logic       cout,
  output logic [7:0] lres
);

  logic [8:0] full;
  logic [4:0] nib;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    nib  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    sum  = full[7:0];
    cout = full[8];
    half = nib[4];
    case (op)
      OP_OR:   lres = a | b;
      OP_XOR:  lres = a ^ b;
      default: lres = a & b;
    endcase
  end

endmodule

// File: rtl/alu_chain.sv
// Multi-byte SM83-style ALU that processes one byte per clock, LSB first,
// through a single reused alu_byte slice.
//   clk, rst      : clock, asynchronous active-low reset
//   start         : request, accepted only while idle
//   op, acc_in,
//   arg_in, f_in  : operation, operands and incoming flags (latched on accept)
//   busy          : operation in progress
//   done          : one-cycle completion pulse
//   res, f_out    : result and flags, held until the next accepted start
module alu_chain
  import sm83_pkg::*;
#(
  parameter int unsigned BYTES         = 2,
  parameter bit          HALF_FROM_TOP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  alu_op_t            op,
  input  logic [8*BYTES-1:0] acc_in,
  input  logic [8*BYTES-1:0] arg_in,
  input  flags_t             f_in,
  output logic               busy,
  output logic               done,
  output logic [8*BYTES-1:0] res,
  output flags_t             f_out
);

  localparam int unsigned W    = 8 * BYTES;
  localparam logic [1:0]  LAST = 2'(BYTES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   acc_q, arg_q, work_q, work_nx, arg_eff;
  alu_op_t        op_q;
  flags_t         f_q, flags_nx;
  logic [1:0]     idx;
  logic           carry, h0, c0;
  logic [4:0]     sh;
  logic [7:0]     a_byte, b_byte, sum, lres, byte_res;
  logic           half, cout, last, accept, is_logic, sub;
  logic           h_b0, c_b0, z_res;

  assign accept   = (state == IDLE) && start;
  assign last     = (idx == LAST);
  assign sh       = {idx, 3'b000};
  assign a_byte   = 8'(acc_q >> sh);
  assign b_byte   = 8'(arg_q >> sh);
  assign is_logic = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);
  assign sub      = is_sub(op_q);
  assign byte_res = is_logic ? lres : sum;

  alu_byte u_byte (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry),
    .op   (op_q),
    .sum  (sum),
    .half (half),
    .cout (cout),
    .lres (lres)
  );

  // Argument is pre-conditioned once at accept so the slice only ever adds.
  always_comb begin
    case (op)
      OP_SUB, OP_SBC, OP_CP: arg_eff = ~arg_in;
      OP_ADDSPE:             arg_eff = W'($signed(arg_in[7:0]));
      default:               arg_eff = arg_in;
    endcase
  end

  always_comb begin
    work_nx = (work_q & ~(W'(8'hFF) << sh)) | (W'(byte_res) << sh);
  end

  // Byte-0 H/C come straight from the slice when byte 0 is also the last byte.
  always_comb begin
    h_b0     = (idx == 2'd0) ? half : h0;
    c_b0     = (idx == 2'd0) ? cout : c0;
    z_res    = (work_nx == '0);
    flags_nx = '0;
    case (op_q)
      OP_AND:        flags_nx = '{z: z_res, n: 1'b0, h: 1'b1, c: 1'b0};
      OP_OR, OP_XOR: flags_nx = '{z: z_res, n: 1'b0, h: 1'b0, c: 1'b0};
      OP_ADDW:       flags_nx = '{z: f_q.z, n: 1'b0,
                                  h: HALF_FROM_TOP ? half : h_b0,
                                  c: HALF_FROM_TOP ? cout : c_b0};
      OP_ADDSPE:     flags_nx = '{z: 1'b0, n: 1'b0, h: h_b0, c: c_b0};
      default:       flags_nx = '{z: z_res, n: sub, h: half ^ sub, c: cout ^ sub};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      arg_q  <= '0;
      work_q <= '0;
      op_q   <= OP_ADD;
      f_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      h0     <= 1'b0;
      c0     <= 1'b0;
      done   <= 1'b0;
      res    <= '0;
      f_out  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        acc_q  <= acc_in;
        arg_q  <= arg_eff;
        op_q   <= op;
        f_q    <= f_in;
        idx    <= '0;
        carry  <= init_carry(op, f_in.c);
        work_q <= '0;
      end else if (state == RUN) begin
        work_q <= work_nx;
        carry  <= cout;
        if (idx == 2'd0) begin
          h0 <= half;
          c0 <= cout;
        end
        if (last) begin
          done  <= 1'b1;
          res   <= (op_q == OP_CP) ? acc_q : work_nx;
          f_out <= flags_nx;
          idx   <= '0;
        end else begin
          idx <= idx + 2'd1;
        end
      end
    end
  end

endmodule
